segre_mm_arbiter: RTL and testbench

Shares the single main-memory port between three requesters: instruction-cache line refill, data-cache line refill, and data-side word write (store-buffer or cache write-through). It sits between the MMU's cache-side logic and the core's mm_* pins. It accepts one transaction at a time and uses fixed-priority arbitration with a starvation guard. Each read's line data is returned to its originator with a registered one-cycle ready pulse.

---
 rtl/segre_mm_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_segre_mm_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mm_arbiter.sv
// segre_mm_arbiter
// ----------------
// Shares the single main-memory port between the instruction-cache refill,
// the data-cache refill and the data-side word write. One transaction is in
// flight at a time. Arbitration in IDLE is fixed priority
// (write > starved ic read > dc read > ic read). A saturating counter stops
// a continuous stream of dc traffic from starving the ic.
//
// Ports
//   clk_i, rsn_i            clock, asynchronous active-low reset
//   ic_rd_req_i/ic_addr_i   ic refill request (held until ic_rdy_o)
//   ic_rdy_o/ic_data_o      one-cycle ready pulse, registered refill line
//   dc_rd_req_i/dc_addr_i   dc refill request (held until dc_rdy_o)
//   dc_rdy_o/dc_data_o      one-cycle ready pulse, registered refill line
//   dc_wr_req_i, dc_wr_*    dc word write (held until dc_wr_ack_o)
//   dc_wr_ack_o             one-cycle pulse in the cycle the write is issued
//   mm_rd_o/mm_addr_o       main-memory read strobe (level) and address
//   mm_data_rdy_i/mm_rd_data_i  read line return
//   mm_wr_o, mm_wr_*        main-memory write strobe (one cycle), addr/data/size
//   busy_o                  FSM not in IDLE
//
// Build option
//   SEGRE_MM_ARB_PERF_EN    adds perf_ic_rd_o, perf_dc_rd_o, perf_wr_o
//                           (completed transactions) and perf_wait_o (cycles
//                           with a requester pending but not being served).
//
// Handshake: a request is a level held by the requester until its own
// rdy/ack pulse. The arbiter latches address/data on grant, so requester
// inputs are ignored afterwards; the requester drops req in the cycle after
// the pulse, which is always an IDLE cycle.

package segre_mm_arbiter_pkg;
    typedef enum logic [1:0] {
        MEMOP_BYTE = 2'd0,
        MEMOP_HALF = 2'd1,
        MEMOP_WORD = 2'd2
    } memop_data_type_e;
endpackage

module segre_mm_arbiter
    import segre_mm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LANE_W     = 128,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rd_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_rdy_o,
    output logic [LANE_W-1:0] ic_data_o,
    input  logic              dc_rd_req_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    output logic              dc_rdy_o,
    output logic [LANE_W-1:0] dc_data_o,
    input  logic              dc_wr_req_i,
    input  logic [ADDR_W-1:0] dc_wr_addr_i,
    input  logic [WORD_W-1:0] dc_wr_data_i,
    input  memop_data_type_e  dc_wr_type_i,
    output logic              dc_wr_ack_o,
    output logic              mm_rd_o,
    output logic [ADDR_W-1:0] mm_addr_o,
    input  logic              mm_data_rdy_i,
    input  logic [LANE_W-1:0] mm_rd_data_i,
    output logic              mm_wr_o,
    output logic [ADDR_W-1:0] mm_wr_addr_o,
    output logic [WORD_W-1:0] mm_wr_data_o,
    output memop_data_type_e  mm_wr_data_type_o,
    output logic              busy_o
`ifdef SEGRE_MM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ic_rd_o,
    output logic [31:0]       perf_dc_rd_o,
    output logic [31:0]       perf_wr_o,
    output logic [31:0]       perf_wait_o
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IC,
        S_RD_DC,
        S_WR,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    memop_data_type_e    wr_type_q, wr_type_d;
    logic                resp_ic_q, resp_ic_d;   // RESP belongs to the ic
    logic [LANE_W-1:0]   ic_data_q, ic_data_d;
    logic [LANE_W-1:0]   dc_data_q, dc_data_d;

    // Counts dc-side grants made while the ic is waiting; saturates.
    function automatic logic [3:0] starve_bump(input logic [3:0] cnt, input logic ic_pend);
        logic [3:0] res;
        res = cnt;
        if (ic_pend && (cnt < STARVE_LIM)) begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        wr_type_d    = wr_type_q;
        resp_ic_d    = resp_ic_q;
        ic_data_d    = ic_data_q;
        dc_data_d    = dc_data_q;

        case (state_q)
            S_IDLE: begin
                if (!ic_rd_req_i) begin
                    starve_cnt_d = '0;
                end
                // Writes first so a younger dc read never overtakes an
                // older store to the same line.
                if (dc_wr_req_i) begin
                    state_d      = S_WR;
                    addr_d       = dc_wr_addr_i;
                    wr_data_d    = dc_wr_data_i;
                    wr_type_d    = dc_wr_type_i;
                    starve_cnt_d = starve_bump(starve_cnt_q, ic_rd_req_i);
                end else if (ic_rd_req_i && (starve_cnt_q == STARVE_LIM)) begin
                    state_d      = S_RD_IC;
                    addr_d       = ic_addr_i;
                    resp_ic_d    = 1'b1;
                    starve_cnt_d = '0;
                end else if (dc_rd_req_i) begin
                    state_d      = S_RD_DC;
                    addr_d       = dc_addr_i;
                    resp_ic_d    = 1'b0;
                    starve_cnt_d = starve_bump(starve_cnt_q, ic_rd_req_i);
                end else if (ic_rd_req_i) begin
                    state_d      = S_RD_IC;
                    addr_d       = ic_addr_i;
                    resp_ic_d    = 1'b1;
                    starve_cnt_d = '0;
                end
            end
            S_RD_IC: begin
                if (mm_data_rdy_i) begin
                    ic_data_d = mm_rd_data_i;
                    state_d   = S_RESP;
                end
            end
            S_RD_DC: begin
                if (mm_data_rdy_i) begin
                    dc_data_d = mm_rd_data_i;
                    state_d   = S_RESP;
                end
            end
            S_WR:    state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_type_q    <= MEMOP_BYTE;
            resp_ic_q    <= 1'b0;
            ic_data_q    <= '0;
            dc_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_type_q    <= wr_type_d;
            resp_ic_q    <= resp_ic_d;
            ic_data_q    <= ic_data_d;
            dc_data_q    <= dc_data_d;
        end
    end

    // All outputs decode registered state, so they drop to 0 as soon as
    // reset is asserted.
    assign mm_rd_o           = (state_q == S_RD_IC) || (state_q == S_RD_DC);
    assign mm_addr_o         = addr_q;
    assign mm_wr_o           = (state_q == S_WR);
    assign dc_wr_ack_o       = (state_q == S_WR);
    assign mm_wr_addr_o      = addr_q;
    assign mm_wr_data_o      = wr_data_q;
    assign mm_wr_data_type_o = wr_type_q;
    assign ic_rdy_o          = (state_q == S_RESP) && resp_ic_q;
    assign dc_rdy_o          = (state_q == S_RESP) && !resp_ic_q;
    assign ic_data_o         = ic_data_q;
    assign dc_data_o         = dc_data_q;
    assign busy_o            = (state_q != S_IDLE);

`ifdef SEGRE_MM_ARB_PERF_EN
    logic [31:0] perf_ic_q, perf_ic_d;
    logic [31:0] perf_dc_q, perf_dc_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_wait_q, perf_wait_d;
    logic        ic_served, dc_served, waiting;

    always_comb begin
        ic_served   = (state_q == S_RD_IC) || ((state_q == S_RESP) && resp_ic_q);
        dc_served   = (state_q == S_RD_DC) || ((state_q == S_RESP) && !resp_ic_q);
        waiting     = (ic_rd_req_i && !ic_served) ||
                      (dc_rd_req_i && !dc_served) ||
                      (dc_wr_req_i && (state_q != S_WR));
        perf_ic_d   = perf_ic_q + 32'(ic_rdy_o);
        perf_dc_d   = perf_dc_q + 32'(dc_rdy_o);
        perf_wr_d   = perf_wr_q + 32'(dc_wr_ack_o);
        perf_wait_d = perf_wait_q + 32'(waiting);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            perf_ic_q   <= '0;
            perf_dc_q   <= '0;
            perf_wr_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_ic_q   <= perf_ic_d;
            perf_dc_q   <= perf_dc_d;
            perf_wr_q   <= perf_wr_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_ic_rd_o = perf_ic_q;
    assign perf_dc_rd_o = perf_dc_q;
    assign perf_wr_o    = perf_wr_q;
    assign perf_wait_o  = perf_wait_q;
`endif

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Testbench for segre_mm_arbiter: requester driver tasks, a main-memory
// responder with programmable latency, and a negedge monitor that pops
// expected read addresses, refill lines and writes from queues.
module tb_segre_mm_arbiter;
    import segre_mm_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LANE_W = 128;

    logic              clk_i;
    logic              rsn_i;
    logic              ic_rd_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_rdy_o;
    logic [LANE_W-1:0] ic_data_o;
    logic              dc_rd_req_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic              dc_rdy_o;
    logic [LANE_W-1:0] dc_data_o;
    logic              dc_wr_req_i;
    logic [ADDR_W-1:0] dc_wr_addr_i;
    logic [WORD_W-1:0] dc_wr_data_i;
    memop_data_type_e  dc_wr_type_i;
    logic              dc_wr_ack_o;
    logic              mm_rd_o;
    logic [ADDR_W-1:0] mm_addr_o;
    logic              mm_data_rdy_i;
    logic [LANE_W-1:0] mm_rd_data_i;
    logic              mm_wr_o;
    logic [ADDR_W-1:0] mm_wr_addr_o;
    logic [WORD_W-1:0] mm_wr_data_o;
    memop_data_type_e  mm_wr_data_type_o;
    logic              busy_o;
`ifdef SEGRE_MM_ARB_PERF_EN
    logic [31:0]       perf_ic_rd_o, perf_dc_rd_o, perf_wr_o, perf_wait_o;
`endif

    segre_mm_arbiter #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LANE_W(LANE_W), .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .ic_rd_req_i(ic_rd_req_i), .ic_addr_i(ic_addr_i),
        .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o),
        .dc_rd_req_i(dc_rd_req_i), .dc_addr_i(dc_addr_i),
        .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o),
        .dc_wr_req_i(dc_wr_req_i), .dc_wr_addr_i(dc_wr_addr_i),
        .dc_wr_data_i(dc_wr_data_i), .dc_wr_type_i(dc_wr_type_i),
        .dc_wr_ack_o(dc_wr_ack_o),
        .mm_rd_o(mm_rd_o), .mm_addr_o(mm_addr_o),
        .mm_data_rdy_i(mm_data_rdy_i), .mm_rd_data_i(mm_rd_data_i),
        .mm_wr_o(mm_wr_o), .mm_wr_addr_o(mm_wr_addr_o),
        .mm_wr_data_o(mm_wr_data_o), .mm_wr_data_type_o(mm_wr_data_type_o),
        .busy_o(busy_o)
`ifdef SEGRE_MM_ARB_PERF_EN
        ,
        .perf_ic_rd_o(perf_ic_rd_o), .perf_dc_rd_o(perf_dc_rd_o),
        .perf_wr_o(perf_wr_o), .perf_wait_o(perf_wait_o)
`endif
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end
    always @(posedge clk_i) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] rd_addr_exp_q[$];
    logic [LANE_W-1:0] ic_exp_q[$];
    logic [LANE_W-1:0] dc_exp_q[$];
    logic [ADDR_W+WORD_W+1:0] wr_exp_q[$];
    int exp_ic = 0, exp_dc = 0, exp_wr = 0;

    int mem_lat = 3;
    logic resp_rdy = 1'b0, inject_rdy = 1'b0;
    logic [LANE_W-1:0] resp_data = '0;
    assign mm_data_rdy_i = resp_rdy | inject_rdy;
    assign mm_rd_data_i  = resp_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {32'hDEAD_BEEF, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1234_5678};
    endfunction

    // ---------------- main-memory responder ----------------
    int resp_cnt = 0;
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (!mm_rd_o) begin
                resp_cnt  = 0;
                resp_rdy  = 1'b0;
                resp_data = {4{$urandom}};
            end else begin
                resp_cnt++;
                if (resp_cnt == mem_lat) begin
                    resp_rdy  = 1'b1;
                    resp_data = line_of(mm_addr_o);
                end else begin
                    resp_rdy  = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_rd = 1'b0, prev_drdy = 1'b0;
    int rd_len = 0, rd_rise_cyc = 0, wr_cyc = 0, dc_rdy_cnt = 0, dc_at_ic = 0;
    always @(negedge clk_i) begin
        if (!rsn_i) begin
            prev_rd   = 1'b0;
            prev_drdy = 1'b0;
            rd_len    = 0;
        end else begin
            if (mm_rd_o) begin
                if (!prev_rd) begin
                    rd_rise_cyc = cyc;
                    rd_len      = 0;
                    if (rd_addr_exp_q.size() == 0) check("rd_unexpected", 128'(1), 128'(0));
                    else check("rd_addr", 128'(mm_addr_o), 128'(rd_addr_exp_q.pop_front()));
                end
                rd_len++;
            end else if (prev_rd) begin
                check("rd_len", 128'(rd_len), 128'(mem_lat));
            end
            if (ic_rdy_o || dc_rdy_o) begin
                check("rdy_latency", 128'(prev_drdy), 128'(1));
                check("rdy_exclusive", 128'(ic_rdy_o & dc_rdy_o), 128'(0));
            end
            if (ic_rdy_o) begin
                dc_at_ic = dc_rdy_cnt;
                if (ic_exp_q.size() == 0) check("ic_unexpected", 128'(1), 128'(0));
                else check("ic_data", ic_data_o, ic_exp_q.pop_front());
            end
            if (dc_rdy_o) begin
                dc_rdy_cnt++;
                if (dc_exp_q.size() == 0) check("dc_unexpected", 128'(1), 128'(0));
                else check("dc_data", dc_data_o, dc_exp_q.pop_front());
            end
            if (mm_wr_o) begin
                wr_cyc = cyc;
                check("wr_ack", 128'(dc_wr_ack_o), 128'(1));
                if (wr_exp_q.size() == 0) check("wr_unexpected", 128'(1), 128'(0));
                else check("wr_fields", 128'({mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o}),
                           128'(wr_exp_q.pop_front()));
            end
            prev_rd   = mm_rd_o;
            prev_drdy = mm_data_rdy_i && mm_rd_o;
        end
    end

    // ---------------- driver tasks ----------------
    // Waits (bounded) for a response pulse, then returns just after the
    // next rising edge so the caller can drop or change its request.
    task automatic wait_pulse(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if ((which == 0 && ic_rdy_o) || (which == 1 && dc_rdy_o) ||
                (which == 2 && dc_wr_ack_o)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(tag, 128'(0), 128'(1));
        @(posedge clk_i);
        #1;
    endtask

    task automatic ic_read(input logic [ADDR_W-1:0] a);
        ic_exp_q.push_back(line_of(a));
        exp_ic++;
        ic_rd_req_i = 1'b1;
        ic_addr_i   = a;
        wait_pulse(0, "ic_timeout");
        ic_rd_req_i = 1'b0;
        ic_addr_i   = $urandom;
    endtask

    task automatic dc_stream(input int n, input logic [ADDR_W-1:0] base);
        dc_rd_req_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            dc_addr_i = base + ADDR_W'(i * 16);
            dc_exp_q.push_back(line_of(dc_addr_i));
            exp_dc++;
            wait_pulse(1, "dc_timeout");
        end
        dc_rd_req_i = 1'b0;
        dc_addr_i   = $urandom;
    endtask

    task automatic dc_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d,
                            input memop_data_type_e t);
        wr_exp_q.push_back({a, d, t});
        exp_wr++;
        dc_wr_req_i  = 1'b1;
        dc_wr_addr_i = a;
        dc_wr_data_i = d;
        dc_wr_type_i = t;
        wait_pulse(2, "wr_timeout");
        dc_wr_req_i  = 1'b0;
        dc_wr_addr_i = $urandom;
        dc_wr_data_i = $urandom;
    endtask

    task automatic zero_checks();
        check("zero_busy",   128'(busy_o), 128'(0));
        check("zero_mm_rd",  128'({mm_rd_o, mm_wr_o, dc_wr_ack_o, ic_rdy_o, dc_rdy_o}), 128'(0));
        check("zero_addr",   128'({mm_addr_o, mm_wr_addr_o, mm_wr_data_o}), 128'(0));
        check("zero_type",   128'(mm_wr_data_type_o), 128'(0));
        check("zero_ic_data", ic_data_o, 128'(0));
        check("zero_dc_data", dc_data_o, 128'(0));
    endtask

    // ---------------- stimulus ----------------
    logic [ADDR_W-1:0] ra;
    logic [WORD_W-1:0] rd;
    initial begin
        rsn_i = 1'b0;
        ic_rd_req_i = 1'b0; ic_addr_i = '0;
        dc_rd_req_i = 1'b0; dc_addr_i = '0;
        dc_wr_req_i = 1'b0; dc_wr_addr_i = '0; dc_wr_data_i = '0;
        dc_wr_type_i = MEMOP_BYTE;
        repeat (3) @(negedge clk_i);
        zero_checks();
        #2 rsn_i = 1'b1;
        @(posedge clk_i); #1;

        // Single ic read, 5-cycle memory latency.
        mem_lat = 5;
        rd_addr_exp_q.push_back(32'h100);
        fork
            ic_read(32'h100);
            begin
                @(negedge clk_i);
                check("t1_no_rd_at_sample", 128'(mm_rd_o), 128'(0));
                @(negedge clk_i);
                check("t1_rd_next_cycle", 128'(mm_rd_o), 128'(1));
                check("t1_busy", 128'(busy_o), 128'(1));
            end
        join

        // Write and dc read requested together: write first, 1-cycle gap.
        mem_lat = 2;
        rd_addr_exp_q.push_back(32'h300);
        fork
            dc_write(32'h200, 32'h1122_3344, MEMOP_WORD);
            dc_stream(1, 32'h300);
        join
        check("t2_wr_then_rd_gap", 128'(rd_rise_cyc - wr_cyc), 128'(2));

        // ic held while dc keeps requesting: 4 dc reads, then ic.
        mem_lat = 1;
        begin
            int base_cnt;
            base_cnt = dc_rdy_cnt;
            foreach (rd_addr_exp_q[i]) check("t3_q_clean", 128'(1), 128'(0));
            for (int i = 0; i < 4; i++) rd_addr_exp_q.push_back(32'h2000 + 32'(i * 16));
            rd_addr_exp_q.push_back(32'h1000);
            rd_addr_exp_q.push_back(32'h2040);
            rd_addr_exp_q.push_back(32'h2050);
            fork
                ic_read(32'h1000);
                dc_stream(6, 32'h2000);
            join
            check("t3_dc_before_ic", 128'(dc_at_ic - base_cnt), 128'(4));
        end

        // Stray mm_data_rdy_i while idle is ignored; data registers hold.
        inject_rdy = 1'b1;
        @(negedge clk_i);
        check("t4_idle_busy", 128'(busy_o), 128'(0));
        @(posedge clk_i); #1;
        inject_rdy = 1'b0;
        @(negedge clk_i);
        check("t4_no_rdy", 128'({ic_rdy_o, dc_rdy_o, busy_o}), 128'(0));
        check("t4_ic_hold", ic_data_o, line_of(32'h1000));
        check("t4_dc_hold", dc_data_o, line_of(32'h2050));
        @(posedge clk_i); #1;

        // Reset pulse in the middle of a dc read.
        mem_lat = 20;
        rd_addr_exp_q.push_back(32'h3000);
        dc_rd_req_i = 1'b1;
        dc_addr_i   = 32'h3000;
        repeat (3) @(negedge clk_i);
        check("t5_in_read", 128'(mm_rd_o), 128'(1));
        #2 rsn_i = 1'b0;
        #1 zero_checks();
        dc_rd_req_i = 1'b0;
        exp_ic = 0; exp_dc = 0; exp_wr = 0;
        @(negedge clk_i);
        #2 rsn_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("t5_no_dc_rdy", 128'({dc_rdy_o, busy_o}), 128'(0));
        end
        mem_lat = 3;
        @(posedge clk_i); #1;
        rd_addr_exp_q.push_back(32'h3100);
        dc_stream(1, 32'h3100);

        // Random ic reads and writes; inputs scribbled after grant.
        for (int i = 0; i < 3; i++) begin
            mem_lat = $urandom_range(1, 6);
            ra = {$urandom_range(0, 32'hFFFF), 4'h0};
            rd_addr_exp_q.push_back(ra);
            fork
                ic_read(ra);
                begin @(posedge clk_i); #1 ic_addr_i = ~ra; end
            join
            ra = $urandom;
            rd = $urandom;
            fork
                dc_write(ra, rd, memop_data_type_e'(2'($urandom_range(0, 2))));
                begin @(posedge clk_i); #1 dc_wr_addr_i = ~ra; dc_wr_data_i = ~rd; end
            join
        end
        repeat (3) @(negedge clk_i);

        check("end_queues_empty", 128'(rd_addr_exp_q.size() + ic_exp_q.size() +
              dc_exp_q.size() + wr_exp_q.size()), 128'(0));
`ifdef SEGRE_MM_ARB_PERF_EN
        check("perf_ic", 128'(perf_ic_rd_o), 128'(exp_ic));
        check("perf_dc", 128'(perf_dc_rd_o), 128'(exp_dc));
        check("perf_wr", 128'(perf_wr_o), 128'(exp_wr));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
